// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared FSM state and Mode encoding for the mux_scan_nto1 block.
package mux_scan_pkg;

    typedef enum logic {MANUAL, SCAN} state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: combinational next scan index and wrap flag.
// Build option MUX_SCAN_MASK_EN: skip channels whose mask bit is clear.
module mux_scan_next #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] cur_i,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]  mask_i,
`endif
    output logic [SEL_W-1:0] nxt_o,
    output logic             wrap_o,
    output logic             found_o
);
`ifdef MUX_SCAN_MASK_EN
    logic [SEL_W-1:0] k;
    always_comb begin
        nxt_o   = cur_i;
        found_o = 1'b0;
        k       = '0;
        // walk from farthest to nearest so the closest enabled channel above cur_i wins
        for (int i = N_CH; i >= 1; i--) begin
            k = SEL_W'((int'(cur_i) + i) % N_CH);
            if (mask_i[k]) begin
                nxt_o   = k;
                found_o = 1'b1;
            end
        end
        wrap_o = found_o && (nxt_o <= cur_i);
    end
`else
    assign nxt_o   = (cur_i == SEL_W'(N_CH - 1)) ? '0 : cur_i + SEL_W'(1);
    assign wrap_o  = (cur_i == SEL_W'(N_CH - 1));
    assign found_o = 1'b1;
`endif
endmodule

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: N-channel registered mux with manual channel load and auto-scan sequencer.
// Build option MUX_SCAN_MASK_EN: adds ChMask so scanning skips disabled channels.
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8,
    parameter int SEL_W   = $clog2(N_CH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Mode,
    input  logic [SEL_W-1:0]      Sel,
    input  logic                  SelLoad,
    input  logic [DWELL_W-1:0]    Dwell,
    input  logic [N_CH*WIDTH-1:0] MuxIn,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]       ChMask,
`endif
    output logic [WIDTH-1:0]      MuxOut,
    output logic [SEL_W-1:0]      CurSel,
    output logic                  OutValid,
    output logic                  Wrap
);
    localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(N_CH);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d, nxt;
    logic [WIDTH-1:0]   mux_q;
    logic               valid_q, valid_d, wrap_q, wrap_d, started_q;
    logic               load, expire, step, nxt_wrap, found;

    mux_scan_next #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next (
        .cur_i   (sel_q),
`ifdef MUX_SCAN_MASK_EN
        .mask_i  (ChMask),
`endif
        .nxt_o   (nxt),
        .wrap_o  (nxt_wrap),
        .found_o (found)
    );

    always_comb begin
        state_d = (Mode == MODE_SCAN) ? SCAN : MANUAL;
        load    = SelLoad && ({1'b0, Sel} < NCH);
        // a load on the expiry cycle takes priority over the scan step
        expire  = (state_q == SCAN) && (state_d == SCAN) && !load && (cnt_q >= Dwell);
        step    = expire && found;
        sel_d   = load ? Sel : step ? nxt : sel_q;
        cnt_d   = (state_q != SCAN || state_d != state_q || load || expire) ? '0 : cnt_q + DWELL_W'(1);
        wrap_d  = step && nxt_wrap;
        valid_d = started_q && (sel_d == sel_q);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= MANUAL;
            cnt_q     <= '0;
            sel_q     <= '0;
            mux_q     <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            mux_q     <= MuxIn[sel_q*WIDTH +: WIDTH];
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            started_q <= 1'b1;
        end
    end

    assign MuxOut   = mux_q;
    assign CurSel   = sel_q;
    assign OutValid = valid_q;
    assign Wrap     = wrap_q;
endmodule
